weight_row_mac: RTL
===================

// Module: weight_row_mac
// PURPOSE
//  Dot-product engine that consumes one 28-entry weight row and one 28-entry input row
//  (one image row) and produces a single 16-bit Q8.8 partial neuron sum plus bias.
//  Sits directly downstream of a per-row weight BRAM and an input-pixel BRAM.
//  It sequences both BRAMs' addresses, multiplies and accumulates, then saturates.
//  It hands the result to the activation/next layer over a valid/ready handshake.
// PARAMETERS
//  N     28  elements per row (BRAM depth)
//  DW    16  data width of weights, pixels, bias and result (signed Q8.8)
//  AW     5  BRAM address width
//  FRAC   8  fractional bits
//  ACCW  40  accumulator width (signed)
// PORTS
//  CLK        in   1   clock; all block logic on posedge (BRAMs read on negedge)
//  RST        in   1   asynchronous, active-high reset
//  START      in   1   one-cycle request; sampled only in IDLE
//  BIAS       in   DW  signed Q8.8 bias, sampled on the cycle START is accepted
//  BUSY       out  1   high from START acceptance until the output handshake completes
//  W_ADDR     out  AW  weight BRAM address
//  W_EN       out  1   weight BRAM enable; the parent ties BRAM WE low
//  W_DO       in   DW  weight BRAM read data
//  X_ADDR     out  AW  pixel BRAM address
//  X_EN       out  1   pixel BRAM enable
//  X_DO       in   DW  pixel BRAM read data
//  OUT_DATA   out  DW  saturated Q8.8 result
//  OUT_VALID  out  1   result valid; held until OUT_READY
//  OUT_READY  in   1   downstream accept
//  OUT_OVF    out  1   result was saturated; qualified by OUT_VALID
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, accumulator 0, index 0.
//  - FSM states: IDLE -> FETCH -> DRAIN -> FINAL -> OUT -> IDLE.
//    IDLE: START=1 latches BIAS, clears acc, goes to FETCH.
//    FETCH: N cycles. Cycle k drives W_ADDR=X_ADDR=k with W_EN=X_EN=1.
//      The BRAM updates DO on the following negedge, so data for address k is
//      sampled on posedge k+1.
//    Pipeline: posedge k+1 registers prod = W_DO*X_DO (signed 32b, Q16.16).
//      posedge k+2 adds prod, sign-extended to ACCW, into acc.
//    DRAIN: 2 cycles to flush the product and accumulate stages. EN=0, ADDR held at N-1.
//    FINAL: 1 cycle. sum = acc + (sign-ext BIAS << FRAC); shift = sum >>> FRAC
//      (arithmetic, truncation toward -inf). Saturate shift to [-32768, 32767].
//      OUT_OVF=1 iff clipped. Register the result into OUT_DATA.
//    OUT: OUT_VALID=1, OUT_DATA and OUT_OVF stable. On OUT_VALID&OUT_READY go to IDLE:
//      BUSY, OUT_VALID and OUT_OVF clear next cycle; OUT_DATA keeps its last value.
//  - Latency: START accepted at posedge 0 -> OUT_VALID first high after posedge N+4
//    (32 for N=28). The next START is accepted no earlier than the cycle after the handshake.
//  - START outside IDLE is ignored (not queued). START and handshake in the same cycle:
//    START is ignored.
//  - W_EN/X_EN are 0 outside FETCH. The address never exceeds N-1 and does not wrap.
//  - RST mid-operation aborts immediately to reset values. The aborted result is never emitted.
//  - OUT_READY high while OUT_VALID low has no effect.
// STRUCTURE
//  - Shared package/header ann_defs: DW, FRAC, N, AW; state encoding localparams
//    (IDLE, FETCH, DRAIN, FINAL, OUT); Q8.8 constants ONE=16'h0100, QMAX=16'h7FFF,
//    QMIN=16'h8000.
//  - One sub-module: q88_sat (ACCW-bit signed in -> DW-bit saturated out + ovf flag),
//    combinational, reused by the activation stage.
//  - The top holds the FSM, index counter, product register and accumulator.
// TESTING (bench models both BRAMs as negedge-read 28x16 arrays)
//  1 All W=0x0100, all X=0x0100, BIAS=0 -> OUT_DATA=0x1C00, OVF=0.
//    OUT_VALID exactly 32 cycles after START. Addresses 0..27 each issued once.
//  2 W[k]=+/-0x0100 alternating (even +), X[k]=k*0x0100, BIAS=0xFF00
//    -> sum=-14.0-1.0 -> OUT_DATA=0xF100, OVF=0.
//  3 All W=0x7FFF, all X=0x7FFF -> OUT_DATA=0x7FFF, OVF=1.
//    All W=0x8000, X=0x7FFF -> OUT_DATA=0x8000, OVF=1.
//  4 Backpressure: OUT_READY low 5 cycles after OUT_VALID, with a START pulse inside
//    that window -> data/OVF stable, START ignored, BUSY high.
//    Handshake on the 6th cycle -> IDLE next cycle.
//  5 Assert RST while W_ADDR=10 -> all outputs 0 immediately, no OUT_VALID.
//    Release RST, rerun scenario 1 -> 0x1C00.
//  6 Two back-to-back runs with START asserted the cycle after the handshake
//    -> both accepted, correct independent results (acc cleared).

Source files
------------

// File: rtl/ann_defs.sv
// Shared widths, FSM encoding and Q8.8 constants for the row-MAC datapath and the
// activation stage.
package ann_defs;
  localparam int unsigned N    = 28;
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 5;
  localparam int unsigned FRAC = 8;
  localparam int unsigned ACCW = 40;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    FINAL = 3'd3,
    OUT   = 3'd4
  } state_e;

  localparam logic [DW-1:0] ONE  = 16'h0100;
  localparam logic [DW-1:0] QMAX = 16'h7FFF;
  localparam logic [DW-1:0] QMIN = 16'h8000;
endpackage

// File: rtl/q88_sat.sv
// Arithmetic right shift of a wide signed accumulator followed by saturation to Q8.8.
module q88_sat
  import ann_defs::*;
#(
  parameter int unsigned IW = ACCW,
  parameter int unsigned SH = FRAC
) (
  input  logic signed [IW-1:0] din,
  output logic        [DW-1:0] dout,
  output logic                 ovf
);
  logic signed [IW-1:0] shifted;

  always_comb begin
    shifted = din >>> SH;
    dout    = shifted[DW-1:0];
    ovf     = 1'b0;
    // Fits in DW bits only when every bit above the result sign bit matches it.
    if (!(&shifted[IW-1:DW-1]) && (|shifted[IW-1:DW-1])) begin
      ovf  = 1'b1;
      dout = shifted[IW-1] ? QMIN : QMAX;
    end
  end
endmodule

// File: rtl/weight_row_mac.sv
// Row dot-product engine: walks both BRAMs, multiply-accumulates, adds bias,
// saturates to Q8.8 and presents the result over valid/ready.
module weight_row_mac
  import ann_defs::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [DW-1:0] BIAS,
  output logic          BUSY,
  output logic [AW-1:0] W_ADDR,
  output logic          W_EN,
  input  logic [DW-1:0] W_DO,
  output logic [AW-1:0] X_ADDR,
  output logic          X_EN,
  input  logic [DW-1:0] X_DO,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_OVF
);
  state_e                   state;
  logic                     drain_cnt;
  logic signed [DW-1:0]     bias_q;
  logic signed [2*DW-1:0]   prod;
  logic                     prod_vld;
  logic signed [ACCW-1:0]   acc;
  logic signed [ACCW-1:0]   bias_ext;
  logic signed [ACCW-1:0]   sum;
  logic        [DW-1:0]     sat_data;
  logic                     sat_ovf;

  assign X_ADDR   = W_ADDR;
  assign X_EN     = W_EN;
  assign bias_ext = {{(ACCW-DW){bias_q[DW-1]}}, bias_q};
  assign sum      = acc + (bias_ext <<< FRAC);

  q88_sat #(
    .IW(ACCW),
    .SH(FRAC)
  ) u_sat (
    .din (sum),
    .dout(sat_data),
    .ovf (sat_ovf)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      bias_q    <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      W_ADDR    <= '0;
      W_EN      <= 1'b0;
      BUSY      <= 1'b0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OUT_OVF   <= 1'b0;
    end else begin
      prod_vld <= 1'b0;
      if (prod_vld) acc <= acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
      unique case (state)
        IDLE: begin
          if (START) begin
            bias_q <= BIAS;
            acc    <= '0;
            W_ADDR <= '0;
            W_EN   <= 1'b1;
            BUSY   <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          // Read data for the current address arrived on the preceding negedge.
          prod     <= $signed(W_DO) * $signed(X_DO);
          prod_vld <= 1'b1;
          if (W_ADDR == AW'(N - 1)) begin
            W_EN      <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            W_ADDR <= W_ADDR + AW'(1);
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= FINAL;
        end
        FINAL: begin
          OUT_DATA <= sat_data;
          OUT_OVF  <= sat_ovf;
          state    <= OUT;
        end
        OUT: begin
          if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
            OUT_OVF   <= 1'b0;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end else begin
            OUT_VALID <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
